ofm_pingpong_buf: RTL
=====================

Name: ofm_pingpong_buf

Overview:
- Double-buffered output-feature-map store directly downstream of the conv write DMA.
- Accepts the write DMA's shared data/address/first/last stream, plus one valid/ready pair per bank, and writes each beat into bank 0 or bank 1.
- Tracks each bank's fill state and word count.
- Exposes completed banks to the next-layer reader in strict ping-pong order, with 1-cycle read latency and an explicit release.

Parameters:
- DW, 8, bits per lane
- DN, 7, lanes per word (word width DN*DW)
- AW, 14, address width; each bank holds 2^AW words

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- ofm_data  in  DN*DW  write data, shared by both banks
- ofm_addr  in  AW  write word address, shared
- ofm_addr_first  in  1  first beat of a bank fill
- ofm_addr_last  in  1  last beat of a bank fill
- ofm_addr_valid1  in  1  write request to bank 0
- ofm_addr_ready1  out  1  bank 0 can accept
- ofm_addr_valid2  in  1  write request to bank 1
- ofm_addr_ready2  out  1  bank 1 can accept
- rd_avail  out  1  bank at read pointer is FULL
- rd_bank  out  1  read pointer (bank index)
- rd_len  out  AW+1  word count of bank at read pointer
- rd_addr  in  AW  read word address
- rd_valid  in  1  read request
- rd_ready  out  1  equals rd_avail
- rd_data  out  DN*DW  read data
- rd_data_valid  out  1  rd_data qualifier
- rd_release  in  1  release bank at read pointer

Behaviour:
- Reset (async assert, sync deassert assumed at system level):
  - both bank states EMPTY, counts 0, rd_bank 0, rd_data_valid 0, rd_data 0.
  - ready1 and ready2 are 1 after reset; rd_avail 0.
  - RAM contents are not reset.
- Bank state per bank: EMPTY(0), FILL(1), FULL(2).
  - readyK = (stateK != FULL), combinational from state only; it does not depend on validK.
- Write beat on bank K: validK & readyK.
  - mem_K[ofm_addr] <= ofm_data.
  - Count: if first, cntK <= 1; else cntK <= cntK+1, saturating at 2^AW.
  - State: last -> FULL (including first&last on one beat); else EMPTY or FILL -> FILL.
  - A beat without first on an EMPTY bank is written, goes to FILL and continues the count from 0.
- Both valids asserted in one cycle: each bank handles its own handshake independently, both may write the same addr/data.
- Read side:
  - rd_avail = (state[rd_bank] == FULL); rd_len = cnt[rd_bank].
  - Read accepted on rd_valid & rd_ready.
  - rd_data is registered: valid exactly 1 cycle after accept, with rd_data_valid=1 for that cycle only.
  - Without an accept, rd_data_valid is 0 and rd_data holds its last value.
  - Back-to-back reads sustain 1 word per cycle.
- Release, on rd_release & rd_avail:
  - state[rd_bank] <= EMPTY, cnt[rd_bank] <= 0, rd_bank toggles.
  - rd_release while !rd_avail is ignored.
  - A read and a release in the same cycle: the read uses the old bank, its data is returned next cycle, then the release takes effect.
  - The released bank's ready rises the next cycle.
- Non-current bank: a FULL bank that is not at rd_bank stays FULL and invisible to the reader until the pointer reaches it.
- Addresses are always in range (depth = 2^AW); no bounds check.
- Reset mid-fill or mid-read: states return to EMPTY immediately, and any in-flight rd_data_valid is dropped.

Decomposition:
- Shared package holds:
  - bank state encodings EMPTY/FILL/FULL (2-bit)
  - derived widths: WORD_W = DN*DW, CNT_W = AW+1
- Sub-module ofm_bank, instantiated twice. It contains:
  - single-port-write / single-port-read RAM with registered read
  - state register and count
  - ready output, full output, release input
- The top level holds rd_bank, the read mux and rd_data_valid.

Test Plan:
- Reset then fill bank 0: valid1 beats with addr 0..9, first on 0, last on 9, data = addr*3 -> ready1 drops the cycle after beat 9; rd_avail=1, rd_bank=0, rd_len=10; ready2 stays 1.
- Readback: rd_valid on addr 0..9 back-to-back -> rd_data_valid on the 10 following cycles, with data 0,3,...,27 in order.
- Ping-pong order: fill bank 1 (len 4) while bank 0 is FULL -> rd_bank stays 0. Release -> rd_bank=1, rd_len=4 the next cycle; ready1=1 the next cycle.
- Single-beat fill: first&last on one valid2 beat -> bank 1 FULL, len 1.
- Back-pressure and read/release overlap:
  - holding valid1 while bank 0 is FULL performs no write; contents are unchanged on later readback.
  - a read and a release in the same cycle return the old bank's data; rd_release while rd_avail=0 has no effect.
- Reset mid-operation: assert rst_n=0 during a fill of bank 1 with bank 0 FULL -> both readys 1, rd_avail 0, rd_bank 0, rd_data_valid 0 immediately.

Source files
------------

// File: rtl/ofm_pingpong_buf_pkg.sv
// Shared definitions for the OFM ping-pong buffer: default geometry, derived widths
// and the per-bank fill-state encoding.
package ofm_pingpong_buf_pkg;

  localparam int OFM_DW = 8;
  localparam int OFM_DN = 7;
  localparam int OFM_AW = 14;

  localparam int WORD_W = OFM_DN * OFM_DW;
  localparam int CNT_W  = OFM_AW + 1;

  typedef logic [1:0] bank_st_t;

  localparam bank_st_t ST_EMPTY = 2'd0;
  localparam bank_st_t ST_FILL  = 2'd1;
  localparam bank_st_t ST_FULL  = 2'd2;

endpackage

// File: rtl/ofm_pingpong_buf_bank.sv
// One OFM bank: word RAM with registered read, fill state and a saturating word count.
module ofm_bank
  import ofm_pingpong_buf_pkg::*;
#(
  parameter int WW = WORD_W,
  parameter int AW = OFM_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_valid_i,
  output logic          wr_ready_o,
  input  logic [WW-1:0] wr_data_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic          wr_first_i,
  input  logic          wr_last_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [WW-1:0] rd_data_o,
  output logic          full_o,
  output logic [AW:0]   cnt_o,
  input  logic          release_i
);

  localparam logic [AW:0] CNT_MAX = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};

  logic [WW-1:0] mem_q [2**AW];
  logic [WW-1:0] rd_data_q;
  bank_st_t      state_q, state_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          wr_fire;

  function automatic logic [AW:0] sat_inc(input logic [AW:0] c);
    return (c == CNT_MAX) ? c : c + CNT_ONE;
  endfunction

  assign wr_ready_o = (state_q != ST_FULL);
  assign full_o     = (state_q == ST_FULL);
  assign cnt_o      = cnt_q;
  assign rd_data_o  = rd_data_q;
  assign wr_fire    = wr_valid_i & wr_ready_o;

  // Writes and releases never collide: a write needs a non-FULL bank, a release a FULL one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (wr_fire) begin
      cnt_d   = wr_first_i ? CNT_ONE : sat_inc(cnt_q);
      state_d = wr_last_i ? ST_FULL : ST_FILL;
    end else if (release_i && (state_q == ST_FULL)) begin
      cnt_d   = '0;
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

endmodule

// File: rtl/ofm_pingpong_buf.sv
// Double-buffered output-feature-map store: two banks written by the conv write DMA,
// handed to the next-layer reader in strict ping-pong order with explicit release.
module ofm_pingpong_buf
  import ofm_pingpong_buf_pkg::*;
#(
  parameter int DW = OFM_DW,
  parameter int DN = OFM_DN,
  parameter int AW = OFM_AW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DN*DW-1:0] ofm_data,
  input  logic [AW-1:0]    ofm_addr,
  input  logic             ofm_addr_first,
  input  logic             ofm_addr_last,
  input  logic             ofm_addr_valid1,
  output logic             ofm_addr_ready1,
  input  logic             ofm_addr_valid2,
  output logic             ofm_addr_ready2,
  output logic             rd_avail,
  output logic             rd_bank,
  output logic [AW:0]      rd_len,
  input  logic [AW-1:0]    rd_addr,
  input  logic             rd_valid,
  output logic             rd_ready,
  output logic [DN*DW-1:0] rd_data,
  output logic             rd_data_valid,
  input  logic             rd_release
);

  localparam int WW = DN * DW;

  logic          rd_bank_q, rd_bank_d;
  logic          rd_sel_q, rd_sel_d;
  logic          rd_dv_q;
  logic          rd_acc, rel_acc;
  logic          full0, full1;
  logic [AW:0]   cnt0, cnt1;
  logic [WW-1:0] data0, data1;

  assign rd_avail = rd_bank_q ? full1 : full0;
  assign rd_ready = rd_avail;
  assign rd_bank  = rd_bank_q;
  assign rd_len   = rd_bank_q ? cnt1 : cnt0;
  assign rd_acc   = rd_valid & rd_avail;
  assign rel_acc  = rd_release & rd_avail;

  ofm_bank #(.WW(WW), .AW(AW)) u_bank0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_valid_i (ofm_addr_valid1),
    .wr_ready_o (ofm_addr_ready1),
    .wr_data_i  (ofm_data),
    .wr_addr_i  (ofm_addr),
    .wr_first_i (ofm_addr_first),
    .wr_last_i  (ofm_addr_last),
    .rd_en_i    (rd_acc & ~rd_bank_q),
    .rd_addr_i  (rd_addr),
    .rd_data_o  (data0),
    .full_o     (full0),
    .cnt_o      (cnt0),
    .release_i  (rel_acc & ~rd_bank_q)
  );

  ofm_bank #(.WW(WW), .AW(AW)) u_bank1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_valid_i (ofm_addr_valid2),
    .wr_ready_o (ofm_addr_ready2),
    .wr_data_i  (ofm_data),
    .wr_addr_i  (ofm_addr),
    .wr_first_i (ofm_addr_first),
    .wr_last_i  (ofm_addr_last),
    .rd_en_i    (rd_acc & rd_bank_q),
    .rd_addr_i  (rd_addr),
    .rd_data_o  (data1),
    .full_o     (full1),
    .cnt_o      (cnt1),
    .release_i  (rel_acc & rd_bank_q)
  );

  // rd_sel remembers which bank served the last read, so rd_data holds across a pointer toggle.
  assign rd_data = rd_sel_q ? data1 : data0;

  always_comb begin
    rd_bank_d = rd_bank_q;
    rd_sel_d  = rd_sel_q;
    if (rd_acc) begin
      rd_sel_d = rd_bank_q;
    end
    if (rel_acc) begin
      rd_bank_d = ~rd_bank_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_bank_q <= 1'b0;
      rd_sel_q  <= 1'b0;
      rd_dv_q   <= 1'b0;
    end else begin
      rd_bank_q <= rd_bank_d;
      rd_sel_q  <= rd_sel_d;
      rd_dv_q   <= rd_acc;
    end
  end

  assign rd_data_valid = rd_dv_q;

endmodule
